// File: rtl/cm3_output_arb_rr.sv
// cm3_output_arb_rr
// Round-robin arbiter for one bus-matrix output stage. Returns a registered
// port number and a no_port flag, and keeps the grant for the length of a
// defined-length burst, for a capped INCR burst, and for a locked sequence.
module cm3_output_arb_rr #(
    parameter int NUM_PORTS = 2,
    parameter int PORT_BASE = 2,
    parameter int ID_W      = 3,
    parameter int MAX_BEATS = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [ID_W-1:0]      addr_in_port,
    output logic                 no_port
);

    localparam int PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    // Wide enough for the INCR cap and for the 16-beat fixed bursts alike.
    localparam int CNT_RAW = $clog2(MAX_BEATS) + 1;
    localparam int CNT_W   = (CNT_RAW > 4) ? CNT_RAW : 4;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic {
        ST_ARB,
        ST_BURST
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [ID_W-1:0]    addr_nxt;
    logic               no_port_nxt;
    logic               burst_hold;
    logic               hold;
    logic               burst_start;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;

    assign burst_start = HSELM && (HTRANSM == TR_NONSEQ) && (HBURSTM != 3'b000);

    // Beats remaining after the NONSEQ beat, indexed by HBURST.
    function automatic logic [CNT_W-1:0] burst_len_m1(input logic [2:0] hburst);
        logic [CNT_W-1:0] len;
        case (hburst)
            3'b010, 3'b011: len = CNT_W'(3);
            3'b100, 3'b101: len = CNT_W'(7);
            3'b110, 3'b111: len = CNT_W'(15);
            3'b001:         len = CNT_W'(MAX_BEATS - 1);
            default:        len = '0;
        endcase
        return len;
    endfunction

    // First set request scanning upward from the port after the pointer.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                               input logic [PTR_W-1:0]     p);
        logic             found;
        logic [PTR_W-1:0] idx_w;
        int               idx;
        found = 1'b0;
        idx_w = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(p) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && r[idx]) begin
                found = 1'b1;
                idx_w = PTR_W'(idx);
            end
        end
        return {found, idx_w};
    endfunction

    // State register: burst tracker, pointer and registered grant; frozen while HREADYM=0.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state        <= ST_ARB;
            cnt          <= '0;
            ptr          <= PTR_W'(NUM_PORTS - 1);
            addr_in_port <= '0;
            no_port      <= 1'b1;
        end else if (HREADYM) begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            ptr          <= ptr_nxt;
            addr_in_port <= addr_nxt;
            no_port      <= no_port_nxt;
        end
    end

    // Next-state logic: burst tracking and the burst part of the hold decision.
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        burst_hold = 1'b0;
        if (state == ST_ARB) begin
            if (burst_start) begin
                state_nxt  = ST_BURST;
                cnt_nxt    = burst_len_m1(HBURSTM);
                burst_hold = 1'b1;
            end
        end else begin
            if (HSELM && (HTRANSM == TR_SEQ)) begin
                // Last-beat check precedes the decrement so the counter never wraps.
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = ST_ARB;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt    = cnt - CNT_W'(1);
                    burst_hold = 1'b1;
                end
            end else if (HSELM && (HTRANSM == TR_BUSY)) begin
                burst_hold = 1'b1;
            end else if (burst_start) begin
                cnt_nxt    = burst_len_m1(HBURSTM);
                burst_hold = 1'b1;
            end else begin
                // SINGLE, IDLE or deselected: burst ended early.
                state_nxt = ST_ARB;
                cnt_nxt   = '0;
            end
        end
    end

    // Output logic: keep the grant while held, otherwise pick the next requester.
    always_comb begin
        {win_found, win_idx} = rr_pick(req, ptr);
        hold        = HMASTLOCKM | burst_hold;
        addr_nxt    = addr_in_port;
        no_port_nxt = no_port;
        ptr_nxt     = ptr;
        if (!hold) begin
            if (win_found) begin
                addr_nxt    = ID_W'(PORT_BASE + int'(win_idx));
                no_port_nxt = 1'b0;
                ptr_nxt     = win_idx;
            end else begin
                no_port_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cm3_output_arb_rr.sv
// Self-checking bench for cm3_output_arb_rr (NUM_PORTS=2, PORT_BASE=2,
// MAX_BEATS=16). Expected grants are pushed to a scoreboard queue as each
// cycle's stimulus is driven and popped after the following HCLK edge.
module tb_cm3_output_arb_rr;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] INCR8  = 3'b101;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic [1:0] req = 2'b11;
    logic       HREADYM = 1'b1;
    logic       HSELM = 1'b1;
    logic [1:0] HTRANSM = NONSEQ;
    logic [2:0] HBURSTM = SINGLE;
    logic       HMASTLOCKM = 1'b0;
    logic [2:0] addr_in_port;
    logic       no_port;

    typedef struct {
        logic [2:0] addr;
        logic       nop;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    cm3_output_arb_rr #(
        .NUM_PORTS(2),
        .PORT_BASE(2),
        .ID_W(3),
        .MAX_BEATS(16)
    ) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .req(req),
        .HREADYM(HREADYM),
        .HSELM(HSELM),
        .HTRANSM(HTRANSM),
        .HBURSTM(HBURSTM),
        .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(addr_in_port),
        .no_port(no_port)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of stimulus, queue its expected grant, compare after the edge.
    task automatic step(input logic [1:0] r, input logic rdy, input logic [1:0] tr,
                        input logic [2:0] bu, input logic lk,
                        input logic [2:0] ea, input logic en, input string nm);
        exp_t e;
        req        = r;
        HREADYM    = rdy;
        HSELM      = 1'b1;
        HTRANSM    = tr;
        HBURSTM    = bu;
        HMASTLOCKM = lk;
        e.addr = ea;
        e.nop  = en;
        e.name = nm;
        sb.push_back(e);
        @(posedge HCLK);
        #1;
        e = sb.pop_front();
        vectors++;
        if (addr_in_port !== e.addr || no_port !== e.nop) begin
            miscompares++;
            $display("FAIL %s: got addr_in_port=%0d no_port=%b, want addr_in_port=%0d no_port=%b",
                     e.name, addr_in_port, no_port, e.addr, e.nop);
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        vectors++;
        if (no_port !== 1'b1 || addr_in_port !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: got addr_in_port=%0d no_port=%b, want 0 1",
                     addr_in_port, no_port);
        end
        @(negedge HCLK);
        HRESET = 1'b0;
        step(2'b11, 1'b1, NONSEQ, SINGLE, 1'b0, 3'd2, 1'b0, "rr_first");
        step(2'b11, 1'b1, NONSEQ, SINGLE, 1'b0, 3'd3, 1'b0, "rr_second");
        step(2'b11, 1'b1, NONSEQ, SINGLE, 1'b0, 3'd2, 1'b0, "rr_third");
        step(2'b11, 1'b1, NONSEQ, SINGLE, 1'b0, 3'd3, 1'b0, "rr_fourth");
    endtask

    task automatic test_burst();
        step(2'b11, 1'b1, NONSEQ, SINGLE, 1'b0, 3'd2, 1'b0, "incr4_grant");
        step(2'b11, 1'b1, NONSEQ, INCR4,  1'b0, 3'd2, 1'b0, "incr4_beat1");
        step(2'b11, 1'b1, SEQ,    INCR4,  1'b0, 3'd2, 1'b0, "incr4_beat2");
        step(2'b11, 1'b1, SEQ,    INCR4,  1'b0, 3'd2, 1'b0, "incr4_beat3");
        step(2'b11, 1'b1, SEQ,    INCR4,  1'b0, 3'd3, 1'b0, "incr4_beat4_release");
        // Same burst from port 3 with a BUSY inserted mid-burst.
        step(2'b11, 1'b1, NONSEQ, INCR4,  1'b0, 3'd3, 1'b0, "busy_beat1");
        step(2'b11, 1'b1, SEQ,    INCR4,  1'b0, 3'd3, 1'b0, "busy_beat2");
        step(2'b11, 1'b1, BUSY,   INCR4,  1'b0, 3'd3, 1'b0, "busy_hold");
        step(2'b11, 1'b1, SEQ,    INCR4,  1'b0, 3'd3, 1'b0, "busy_beat3");
        step(2'b11, 1'b1, SEQ,    INCR4,  1'b0, 3'd2, 1'b0, "busy_beat4_release");
    endtask

    task automatic test_lock();
        for (int i = 0; i < 6; i++)
            step(2'b11, 1'b1, NONSEQ, SINGLE, 1'b1, 3'd2, 1'b0, $sformatf("lock_hold_%0d", i));
        step(2'b11, 1'b1, NONSEQ, SINGLE, 1'b0, 3'd3, 1'b0, "lock_drop_switch");
    endtask

    task automatic test_no_req();
        step(2'b00, 1'b1, NONSEQ, SINGLE, 1'b0, 3'd3, 1'b1, "no_req_keep_addr");
        step(2'b01, 1'b1, NONSEQ, SINGLE, 1'b0, 3'd2, 1'b0, "req0_only");
        step(2'b01, 1'b1, NONSEQ, SINGLE, 1'b0, 3'd2, 1'b0, "sole_requester_keeps");
    endtask

    task automatic test_hready_freeze();
        logic [1:0] pat [5];
        pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b11; pat[4] = 2'b00;
        for (int i = 0; i < 5; i++)
            step(pat[i], 1'b0, NONSEQ, INCR4, 1'b0, 3'd2, 1'b0, $sformatf("freeze_%0d", i));
        step(2'b11, 1'b1, NONSEQ, SINGLE, 1'b0, 3'd3, 1'b0, "freeze_resume");
    endtask

    task automatic test_incr_cap();
        step(2'b11, 1'b1, NONSEQ, INCR, 1'b0, 3'd3, 1'b0, "incr_beat1");
        for (int b = 2; b <= 15; b++)
            step(2'b11, 1'b1, SEQ, INCR, 1'b0, 3'd3, 1'b0, $sformatf("incr_beat%0d", b));
        step(2'b11, 1'b1, SEQ, INCR, 1'b0, 3'd2, 1'b0, "incr_beat16_release");
        // Early termination: IDLE on the third beat.
        step(2'b11, 1'b1, NONSEQ, INCR, 1'b0, 3'd2, 1'b0, "idle_beat1");
        step(2'b11, 1'b1, SEQ,    INCR, 1'b0, 3'd2, 1'b0, "idle_beat2");
        step(2'b11, 1'b1, IDLE,   INCR, 1'b0, 3'd3, 1'b0, "idle_beat3_release");
    endtask

    task automatic test_reset_mid_burst();
        step(2'b11, 1'b1, NONSEQ, INCR8, 1'b0, 3'd3, 1'b0, "incr8_beat1");
        req     = 2'b11;
        HTRANSM = SEQ;
        #2;
        HRESET = 1'b1;
        #1;
        vectors++;
        if (no_port !== 1'b1 || addr_in_port !== 3'd0) begin
            miscompares++;
            $display("FAIL async_reset_mid_burst: got addr_in_port=%0d no_port=%b, want 0 1",
                     addr_in_port, no_port);
        end
        @(negedge HCLK);
        HRESET = 1'b0;
        step(2'b11, 1'b1, SEQ, INCR8, 1'b0, 3'd2, 1'b0, "post_reset_req0_first");
    endtask

    initial begin
        test_reset();
        test_burst();
        test_lock();
        test_no_req();
        test_hready_freeze();
        test_incr_cap();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
